// File: rtl/bp_me_clint_regs.sv
// bp_me_clint_regs
// CLINT register slave behind the I/O address decode (device base 0x0030_0000).
// It holds mipi (software interrupt), mtimecmp and a free-running mtime that
// advances once every mtime_div_p cycles. It serves one request at a time and
// keeps the response until it is consumed.
//
// Ports
//   clk_i, reset_i          clock, synchronous active-high reset
//   req_v_i / req_ready_o   request handshake (accepted when both are high)
//   req_w_i                 1 = write, 0 = read
//   req_addr_i              full byte address, compared exactly
//   req_size_i              log2 access bytes (2 = 4B, 3 = 8B)
//   req_data_i              write data (4B writes use [31:0])
//   resp_v_o / resp_yumi_i  response valid / consumed
//   resp_data_o             read data (0 on writes and errors)
//   resp_err_o              unmapped, misaligned or illegal-size access
//   software_irq_o          mipi bit 0
//   timer_irq_o             mtime >= mtimecmp (unsigned)
//
// state  | meaning
// eReady | idle, accepts one request
// eResp  | response held on resp_*, waits for resp_yumi_i
module bp_me_clint_regs #(
  parameter int addr_width_p = 40,
  parameter int data_width_p = 64,
  parameter int mtime_div_p  = 8
) (
  input  logic                    clk_i,
  input  logic                    reset_i,
  input  logic                    req_v_i,
  output logic                    req_ready_o,
  input  logic                    req_w_i,
  input  logic [addr_width_p-1:0] req_addr_i,
  input  logic [1:0]              req_size_i,
  input  logic [data_width_p-1:0] req_data_i,
  output logic                    resp_v_o,
  input  logic                    resp_yumi_i,
  output logic [data_width_p-1:0] resp_data_o,
  output logic                    resp_err_o,
  output logic                    software_irq_o,
  output logic                    timer_irq_o
);

  localparam logic [addr_width_p-1:0] mipi_addr_lp     = addr_width_p'(32'h0030_0000);
  localparam logic [addr_width_p-1:0] cmp_lo_addr_lp   = addr_width_p'(32'h0030_4000);
  localparam logic [addr_width_p-1:0] cmp_hi_addr_lp   = addr_width_p'(32'h0030_4004);
  localparam logic [addr_width_p-1:0] time_lo_addr_lp  = addr_width_p'(32'h0030_BFF8);
  localparam logic [addr_width_p-1:0] time_hi_addr_lp  = addr_width_p'(32'h0030_BFFC);

  // A divide-by-1 still needs a one-bit prescaler; it simply stays at 0.
  localparam int ps_width_lp = (mtime_div_p > 1) ? $clog2(mtime_div_p) : 1;
  localparam logic [ps_width_lp-1:0] ps_last_lp = ps_width_lp'(mtime_div_p - 1);

  typedef enum logic {eReady, eResp} state_e;

  state_e state_r, state_n;

  logic [data_width_p-1:0] mtime_r, mtime_n;
  logic [data_width_p-1:0] mtimecmp_r, mtimecmp_n;
  logic                    mipi_r, mipi_n;
  logic [ps_width_lp-1:0]  prescale_r;
  logic                    tick;

  logic [data_width_p-1:0] resp_data_r, rdata, resp_data_n;
  logic                    resp_err_r;

  logic handshake, size_ok, is8, req_err, wr_en;
  logic hit_mipi, hit_cmp_lo, hit_cmp_hi, hit_time_lo, hit_time_hi;

  // FSM
  always_ff @(posedge clk_i) begin
    if (reset_i) state_r <= eReady;
    else         state_r <= state_n;
  end

  always_comb begin
    state_n     = state_r;
    req_ready_o = 1'b0;
    resp_v_o    = 1'b0;
    case (state_r)
      eReady: begin
        req_ready_o = ~reset_i;
        if (req_v_i & ~reset_i) state_n = eResp;
      end
      eResp: begin
        resp_v_o = 1'b1;
        if (resp_yumi_i) state_n = eReady;
      end
      default: state_n = eReady;
    endcase
  end

  // Decode
  assign handshake   = req_v_i & req_ready_o;
  assign size_ok     = req_size_i[1];
  assign is8         = (req_size_i == 2'd3);
  assign hit_mipi    = (req_addr_i == mipi_addr_lp);
  assign hit_cmp_lo  = (req_addr_i == cmp_lo_addr_lp);
  assign hit_cmp_hi  = (req_addr_i == cmp_hi_addr_lp);
  assign hit_time_lo = (req_addr_i == time_lo_addr_lp);
  assign hit_time_hi = (req_addr_i == time_hi_addr_lp);

  // High-half addresses have addr[2]=1, so an 8B access there is misaligned.
  assign req_err = ~size_ok
                 | ~(hit_mipi | hit_cmp_lo | hit_cmp_hi | hit_time_lo | hit_time_hi)
                 | (is8 & (hit_cmp_hi | hit_time_hi));
  assign wr_en   = handshake & req_w_i & ~req_err;

  always_comb begin
    rdata = '0;
    if (hit_mipi)         rdata = data_width_p'(mipi_r);
    else if (hit_cmp_lo)  rdata = is8 ? mtimecmp_r : data_width_p'(mtimecmp_r[31:0]);
    else if (hit_cmp_hi)  rdata = data_width_p'(mtimecmp_r[data_width_p-1:32]);
    else if (hit_time_lo) rdata = is8 ? mtime_r : data_width_p'(mtime_r[31:0]);
    else if (hit_time_hi) rdata = data_width_p'(mtime_r[data_width_p-1:32]);
    resp_data_n = (req_err | req_w_i) ? '0 : rdata;
  end

  // Register updates; a write to mtime overrides that cycle's increment.
  assign tick = (prescale_r == ps_last_lp);

  always_comb begin
    mtime_n    = tick ? mtime_r + 1'b1 : mtime_r;
    mtimecmp_n = mtimecmp_r;
    mipi_n     = mipi_r;
    if (wr_en) begin
      if (hit_mipi) mipi_n = req_data_i[0];
      if (hit_cmp_lo) begin
        if (is8) mtimecmp_n = req_data_i;
        else     mtimecmp_n = {mtimecmp_r[data_width_p-1:32], req_data_i[31:0]};
      end
      if (hit_cmp_hi) mtimecmp_n = {req_data_i[31:0], mtimecmp_r[31:0]};
      if (hit_time_lo) begin
        if (is8) mtime_n = req_data_i;
        else     mtime_n = {mtime_r[data_width_p-1:32], req_data_i[31:0]};
      end
      if (hit_time_hi) mtime_n = {req_data_i[31:0], mtime_r[31:0]};
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      prescale_r  <= '0;
      mtime_r     <= '0;
      mtimecmp_r  <= '1;
      mipi_r      <= 1'b0;
      resp_data_r <= '0;
      resp_err_r  <= 1'b0;
    end else begin
      prescale_r <= tick ? '0 : prescale_r + 1'b1;
      mtime_r    <= mtime_n;
      mtimecmp_r <= mtimecmp_n;
      mipi_r     <= mipi_n;
      if (handshake) begin
        resp_data_r <= resp_data_n;
        resp_err_r  <= req_err;
      end
    end
  end

  assign resp_data_o    = resp_data_r;
  assign resp_err_o     = resp_err_r;
  assign software_irq_o = mipi_r;
  assign timer_irq_o    = (mtime_r >= mtimecmp_r);

endmodule

// File: tb/tb_bp_me_clint_regs.sv
module tb_bp_me_clint_regs;

  localparam int DIV = 8;
  localparam logic [39:0] A_MIPI    = 40'h00_0030_0000;
  localparam logic [39:0] A_CMP_LO  = 40'h00_0030_4000;
  localparam logic [39:0] A_CMP_HI  = 40'h00_0030_4004;
  localparam logic [39:0] A_TIME_LO = 40'h00_0030_BFF8;
  localparam logic [39:0] A_TIME_HI = 40'h00_0030_BFFC;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_v, req_ready, req_w;
  logic [39:0] req_addr;
  logic [1:0]  req_size;
  logic [63:0] req_data;
  logic        resp_v, resp_yumi, resp_err;
  logic [63:0] resp_data;
  logic        sw_irq, tm_irq;

  int n_vec = 0;
  int n_err = 0;

  // Reference model: register contents plus mtime as "value last written
  // + number of prescaler ticks since then".
  longint      cyc = 0;
  logic [63:0] m_cmp;
  logic        m_mipi;
  logic [63:0] m_base;
  longint      m_base_edge;

  bp_me_clint_regs #(.addr_width_p(40), .data_width_p(64), .mtime_div_p(DIV)) dut (
    .clk_i(clk), .reset_i(reset),
    .req_v_i(req_v), .req_ready_o(req_ready), .req_w_i(req_w),
    .req_addr_i(req_addr), .req_size_i(req_size), .req_data_i(req_data),
    .resp_v_o(resp_v), .resp_yumi_i(resp_yumi), .resp_data_o(resp_data),
    .resp_err_o(resp_err), .software_irq_o(sw_irq), .timer_irq_o(tm_irq)
  );

  always #5 clk = ~clk;

  // Number of clock edges since reset release (edge k ticks when k%DIV==DIV-1).
  always @(posedge clk) begin
    if (reset) cyc <= 0;
    else       cyc <= cyc + 1;
  end

  function automatic logic [63:0] mtime_at(input longint e);
    longint lo, hi;
    lo = m_base_edge + 1;
    hi = e - 1;
    if (hi < lo) return m_base;
    return m_base + 64'((hi + 1) / DIV - lo / DIV);
  endfunction

  task automatic model_reset();
    m_cmp       = '1;
    m_mipi      = 1'b0;
    m_base      = '0;
    m_base_edge = -1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic chk_irqs(input string tag);
    chk1({tag, "_swirq"}, sw_irq, m_mipi);
    chk1({tag, "_tmirq"}, tm_irq, mtime_at(cyc) >= m_cmp);
  endtask

  // One request, called and returning at a negedge.
  task automatic access(input bit w, input logic [39:0] a, input logic [1:0] sz,
                        input logic [63:0] d, input int hold, input bit no_yumi);
    longint      k;
    logic [63:0] cur_t, rd;
    bit          err, is8;
    int          guard;
    guard = 0;
    while (req_ready !== 1'b1 && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    chk1("ready_before_req", req_ready, 1'b1);
    req_v = 1'b1; req_w = w; req_addr = a; req_size = sz; req_data = d;
    k     = cyc;
    cur_t = mtime_at(k);
    is8   = (sz == 2'd3);
    err   = (sz < 2'd2);
    rd    = '0;
    if (!err) begin
      case (a)
        A_MIPI:    rd = {63'b0, m_mipi};
        A_CMP_LO:  rd = is8 ? m_cmp : {32'b0, m_cmp[31:0]};
        A_CMP_HI:  if (is8) err = 1'b1; else rd = {32'b0, m_cmp[63:32]};
        A_TIME_LO: rd = is8 ? cur_t : {32'b0, cur_t[31:0]};
        A_TIME_HI: if (is8) err = 1'b1; else rd = {32'b0, cur_t[63:32]};
        default:   err = 1'b1;
      endcase
    end
    if (err || w) rd = '0;
    if (w && !err) begin
      case (a)
        A_MIPI:    m_mipi = d[0];
        A_CMP_LO:  if (is8) m_cmp = d; else m_cmp[31:0] = d[31:0];
        A_CMP_HI:  m_cmp[63:32] = d[31:0];
        A_TIME_LO: begin
          m_base = is8 ? d : {cur_t[63:32], d[31:0]};
          m_base_edge = k;
        end
        A_TIME_HI: begin
          m_base = {d[31:0], cur_t[31:0]};
          m_base_edge = k;
        end
        default: ;
      endcase
    end
    @(posedge clk);
    @(negedge clk);
    req_v = 1'b0;
    req_w = 1'b0;
    chk1("resp_v", resp_v, 1'b1);
    chk("resp_data", resp_data, rd);
    chk1("resp_err", resp_err, err);
    chk1("ready_in_resp", req_ready, 1'b0);
    chk_irqs("after_access");
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      chk1("hold_resp_v", resp_v, 1'b1);
      chk("hold_resp_data", resp_data, rd);
      chk1("hold_resp_err", resp_err, err);
      chk1("hold_ready", req_ready, 1'b0);
    end
    if (!no_yumi) begin
      resp_yumi = 1'b1;
      @(posedge clk);
      @(negedge clk);
      resp_yumi = 1'b0;
      chk1("resp_v_after_yumi", resp_v, 1'b0);
      chk1("ready_after_yumi", req_ready, 1'b1);
    end
  endtask

  task automatic align_tick();
    while ((cyc % DIV) != DIV - 1) @(negedge clk);
  endtask

  logic [39:0] addrs [9];

  initial begin
    int guard;
    reset = 1'b1; req_v = 1'b0; req_w = 1'b0; req_addr = '0; req_size = '0;
    req_data = '0; resp_yumi = 1'b0;
    model_reset();
    repeat (3) @(negedge clk);
    chk1("rst_ready", req_ready, 1'b0);
    chk1("rst_resp_v", resp_v, 1'b0);
    chk("rst_resp_data", resp_data, 64'h0);
    chk1("rst_resp_err", resp_err, 1'b0);
    chk1("rst_swirq", sw_irq, 1'b0);
    chk1("rst_tmirq", tm_irq, 1'b0);
    reset = 1'b0;

    // Idle 40 cycles then read mtime: 5 ticks at divide-by-8.
    repeat (40) @(negedge clk);
    chk_irqs("idle40");
    access(1'b0, A_TIME_LO, 2'd3, '0, 0, 1'b0);

    // Timer compare rising, then falling.
    access(1'b1, A_CMP_LO, 2'd3, 64'h10, 0, 1'b0);
    guard = 0;
    while (mtime_at(cyc) <= 64'h11 && guard < 400) begin
      @(negedge clk);
      chk_irqs("poll_cmp");
      guard++;
    end
    chk1("poll_cmp_reached", guard < 400, 1'b1);
    chk1("tmirq_high", tm_irq, 1'b1);
    access(1'b1, A_CMP_LO, 2'd3, 64'h100, 0, 1'b0);
    chk1("tmirq_low", tm_irq, 1'b0);

    // Software interrupt.
    access(1'b1, A_MIPI, 2'd2, 64'h1, 0, 1'b0);
    access(1'b0, A_MIPI, 2'd3, '0, 0, 1'b0);
    access(1'b1, A_MIPI, 2'd2, 64'hFFFF_FFFE, 0, 1'b0);
    chk1("swirq_cleared", sw_irq, 1'b0);

    // Half writes of mtime landing on tick edges, then wrap.
    align_tick();
    access(1'b1, A_TIME_LO, 2'd2, 64'hFFFF_FFFF, 0, 1'b0);
    align_tick();
    access(1'b1, A_TIME_HI, 2'd2, 64'hFFFF_FFFF, 0, 1'b0);
    access(1'b0, A_TIME_LO, 2'd3, '0, 0, 1'b0);
    repeat (DIV) @(negedge clk);
    access(1'b0, A_TIME_LO, 2'd3, '0, 0, 1'b0);
    access(1'b1, A_TIME_LO, 2'd3, '1, 0, 1'b0);
    repeat (DIV) @(negedge clk);
    access(1'b0, A_TIME_HI, 2'd2, '0, 0, 1'b0);
    access(1'b0, A_TIME_LO, 2'd2, '0, 0, 1'b0);

    // Error accesses leave registers untouched.
    access(1'b0, 40'h00_0030_0008, 2'd3, '0, 0, 1'b0);
    access(1'b0, A_CMP_HI, 2'd3, '0, 0, 1'b0);
    access(1'b0, A_MIPI, 2'd1, '0, 0, 1'b0);
    access(1'b1, A_CMP_LO, 2'd1, 64'h0, 0, 1'b0);
    access(1'b1, A_TIME_HI, 2'd3, 64'h0, 0, 1'b0);
    access(1'b1, A_MIPI, 2'd0, 64'h1, 0, 1'b0);
    access(1'b0, A_CMP_LO, 2'd3, '0, 0, 1'b0);
    access(1'b0, A_MIPI, 2'd2, '0, 0, 1'b0);

    // resp_yumi_i in eReady is ignored.
    resp_yumi = 1'b1;
    repeat (2) @(negedge clk);
    resp_yumi = 1'b0;
    chk1("yumi_idle_ready", req_ready, 1'b1);
    chk1("yumi_idle_resp_v", resp_v, 1'b0);

    // Randomized traffic against the model.
    addrs[0] = A_MIPI;    addrs[1] = A_CMP_LO;  addrs[2] = A_CMP_HI;
    addrs[3] = A_TIME_LO; addrs[4] = A_TIME_HI; addrs[5] = 40'h00_0030_0008;
    addrs[6] = 40'h00_0030_4008; addrs[7] = 40'h00_0030_BFF0; addrs[8] = '0;
    for (int n = 0; n < 80; n++) begin
      int          idx;
      logic [39:0] a;
      idx = int'($urandom_range(0, 8));
      a   = (idx == 8) ? {8'h00, 32'($urandom)} : addrs[idx];
      access(1'($urandom_range(0, 1)), a, 2'($urandom_range(0, 3)),
             {32'($urandom), 32'($urandom)}, int'($urandom_range(0, 3)), 1'b0);
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end

    // Stall with yumi low, then reset while the response is pending.
    access(1'b1, A_MIPI, 2'd2, 64'h1, 0, 1'b0);
    access(1'b1, A_CMP_LO, 2'd3, 64'h5, 0, 1'b0);
    access(1'b0, A_TIME_LO, 2'd3, '0, 5, 1'b1);
    reset = 1'b1;
    req_v = 1'b1; req_w = 1'b1; req_addr = A_CMP_LO; req_size = 2'd3; req_data = 64'h0;
    @(posedge clk);
    @(negedge clk);
    model_reset();
    chk1("rst_resp_drop", resp_v, 1'b0);
    chk1("rst_mid_ready", req_ready, 1'b0);
    chk1("rst_mid_swirq", sw_irq, 1'b0);
    chk1("rst_mid_tmirq", tm_irq, 1'b0);
    chk("rst_mid_data", resp_data, 64'h0);
    req_v = 1'b0; req_w = 1'b0;
    reset = 1'b0;
    access(1'b0, A_CMP_LO, 2'd3, '0, 0, 1'b0);
    access(1'b0, A_TIME_LO, 2'd3, '0, 0, 1'b0);
    access(1'b0, A_MIPI, 2'd3, '0, 0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/bp_me_clint_regs.md
Name: bp_me_clint_regs

Overview:
- Core-local interruptor (CLINT) register slave that sits directly downstream of the I/O address decode.
- Consumes requests the decode steers to the CLINT device (base 0x0030_0000).
- Implements the mipi, mtimecmp and mtime registers, including a prescaled free-running mtime counter.
- Drives the software and timer interrupt lines to the core. Uses a single-outstanding request/response handshake.

Parameters:
- addr_width_p, 40, request address width; matches the physical address width of the I/O map.
- data_width_p, 64, request/response data width; fixed at 64.
- mtime_div_p, 8, core cycles per mtime increment; legal range is 1 or more.

Ports:
- clk_i  input  1  clock
- reset_i  input  1  synchronous active-high reset
- req_v_i  input  1  request valid
- req_ready_o  output  1  request accepted when req_v_i & req_ready_o
- req_w_i  input  1  1 = write, 0 = read
- req_addr_i  input  addr_width_p  full byte address
- req_size_i  input  2  access size log2 bytes; only 2 (4B) and 3 (8B) are legal
- req_data_i  input  64  write data; 4B writes use bits [31:0]
- resp_v_o  output  1  response valid
- resp_yumi_i  input  1  response consumed; legal only while resp_v_o is high
- resp_data_o  output  64  read data; 0 for writes and errors
- resp_err_o  output  1  unmapped, misaligned or illegal-size access
- software_irq_o  output  1  mipi bit 0
- timer_irq_o  output  1  mtime >= mtimecmp, unsigned

Behaviour:
- Clock and reset: one clock; reset is synchronous and active-high.
- Reset values:
  - FSM goes to eReady; mtime = 0; prescaler = 0; mtimecmp = all ones; mipi = 0.
  - resp_v_o = 0, resp_data_o = 0, resp_err_o = 0.
  - software_irq_o = 0, timer_irq_o = 0.
  - req_ready_o = 0 while reset_i is high.
- Address map (exact compare on the full req_addr_i):
  - mipi: 0x0030_0000, 4B or 8B.
  - mtimecmp: 0x0030_4000 for 8B or the low 4B; 0x0030_4004 for the high 4B.
  - mtime: 0x0030_BFF8 for 8B or the low 4B; 0x0030_BFFC for the high 4B.
  - Any other address, an 8B access at addr[2]=1, or req_size_i < 2 sets resp_err_o = 1. No register changes and resp_data_o = 0.
- FSM, eReady:
  - req_ready_o = 1.
  - On handshake, a write commits at that clock edge. Read data and the error flag are captured from the pre-edge register values.
  - Next state is eResp.
- FSM, eResp:
  - req_ready_o = 0, resp_v_o = 1. resp_data_o and resp_err_o are held stable.
  - On resp_yumi_i the FSM returns to eReady. The next request can be accepted one cycle later; there is a mandatory one-cycle bubble.
- Latency: the response is valid exactly 1 cycle after acceptance, then held until resp_yumi_i.
- Width rules:
  - 4B reads return the selected half in [31:0] with [63:32] = 0.
  - 4B writes replace only the addressed half.
  - mipi writes store req_data_i[0]; other bits are ignored. mipi reads as {63'b0, mipi}.
- mtime counter:
  - The prescaler counts 0..mtime_div_p-1.
  - When prescaler == mtime_div_p-1, the prescaler wraps to 0 and mtime increments by 1.
  - mtime is a 64-bit modular counter: 0xFFFF_FFFF_FFFF_FFFF + 1 = 0.
  - With mtime_div_p = 1, mtime increments every cycle.
- Simultaneous tick and mtime write (either half or full): the written value wins and the increment for that cycle is discarded. The prescaler continues unaffected.
- Interrupts:
  - timer_irq_o is a combinational compare of the current mtime and mtimecmp registers. It changes the cycle after the mtime/mtimecmp update edge.
  - software_irq_o = mipi register.
- Reset mid-operation: reset_i in eResp drops the pending response (resp_v_o = 0 next cycle) and applies all reset values. No write from a request coincident with reset_i is committed.
- resp_yumi_i asserted in eReady is ignored.

Test Plan:
- Reset, then idle 40 cycles with mtime_div_p = 8 -> read 8B at 0x0030_BFF8 returns 5; timer_irq_o stays 0 (mtimecmp is all ones).
- Write 8B mtimecmp = 0x10, then poll -> timer_irq_o rises the cycle after mtime becomes 0x10. Then write mtimecmp = 0x100 -> timer_irq_o falls the next cycle.
- Write 0x1 to mipi -> software_irq_o = 1 the next cycle; read returns 0x1. Write 0xFFFF_FFFE -> software_irq_o = 0.
- Write 4B 0xFFFF_FFFF to 0x0030_BFF8, then 4B 0xFFFF_FFFF to 0x0030_BFFC, on a tick cycle -> mtime = 0xFFFF_FFFF_FFFF_FFFF. The next tick wraps mtime to 0.
- Read 0x0030_0008, read 8B at 0x0030_4004, and read with size 1 -> each gives resp_err_o = 1, resp_data_o = 0, and no state change.
- Hold resp_yumi_i low for 5 cycles -> resp_v_o and resp_data_o stay stable and req_ready_o stays 0. Assert reset_i during eResp -> resp_v_o = 0 next cycle and mtimecmp reads all ones.
